rastreador_max_min: RTL and testbench

- Streaming stage directly downstream of Comparador8bits; consumes its igual/mayor/menor flags.
- Accepts a stream of 8-bit unsigned samples over a fixed-length window.
- Tracks the running maximum, the running minimum, and how many samples equalled the final maximum.
- Presents the window result with a valid/ack handshake, then rearms for the next window.

---
 rtl/rastreador_max_min_pkg.sv | 18 +
 rtl/rastreador_max_min_if.sv | 25 ++
 rtl/Comparador8bits.sv | 14 +
 rtl/rastreador_max_min.sv | 157 +++++++++++++++
 tb/tb_rastreador_max_min.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rastreador_max_min_pkg.sv
// Shared definitions for the window max/min tracker: FSM states and register start values.
package rastreador_max_min_pkg;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      ACUMULA = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   localparam logic [7:0] MAX_INICIAL = 8'h00;
   localparam logic [7:0] MIN_INICIAL = 8'hFF;

   // Comparator flags packed as {mayor, igual, menor}; exactly one bit is set.
   localparam logic [2:0] CMP_MAYOR = 3'b100;
   localparam logic [2:0] CMP_IGUAL = 3'b010;
   localparam logic [2:0] CMP_MENOR = 3'b001;

endpackage

// File: rtl/rastreador_max_min_if.sv
// Sample stream, abort and result handshake of the window max/min tracker.
interface rastreador_max_min_if #(
   parameter int CUENTA_W = 8
);
   logic [7:0]          dato;
   logic                dato_valido;
   logic                listo;
   logic                limpiar;
   logic [7:0]          maximo;
   logic [7:0]          minimo;
   logic [CUENTA_W-1:0] repeticiones_max;
   logic [CUENTA_W-1:0] cuenta;
   logic                resultado_valido;
   logic                resultado_ack;

   modport slave (
      input  dato, dato_valido, limpiar, resultado_ack,
      output listo, maximo, minimo, repeticiones_max, cuenta, resultado_valido
   );

   modport master (
      output dato, dato_valido, limpiar, resultado_ack,
      input  listo, maximo, minimo, repeticiones_max, cuenta, resultado_valido
   );
endinterface

// File: rtl/Comparador8bits.sv
// Unsigned 8-bit magnitude comparator producing one-hot igual/mayor/menor flags for a vs b.
module Comparador8bits (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       igual,
   output logic       mayor,
   output logic       menor
);

   assign igual = (a == b);
   assign mayor = (a > b);
   assign menor = (a < b);

endmodule

// File: rtl/rastreador_max_min.sv
// Tracks max, min and max-repeat count over a fixed window of unsigned samples and
// presents the result through a valid/ack handshake before rearming.
module rastreador_max_min
   import rastreador_max_min_pkg::*;
#(
   parameter int LONG_VENTANA = 16,
   parameter int CUENTA_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rastreador_max_min_if.slave  bus
);

   localparam logic [CUENTA_W-1:0] CUENTA_CERO = {CUENTA_W{1'b0}};
   localparam logic [CUENTA_W-1:0] CUENTA_UNO  = CUENTA_W'(1);
   localparam logic [CUENTA_W-1:0] REP_SAT     = {CUENTA_W{1'b1}};
   localparam logic [CUENTA_W-1:0] ULTIMA      = CUENTA_W'(LONG_VENTANA - 1);

   estado_t             estado_q, estado_d;
   logic [7:0]          maximo_q, maximo_d;
   logic [7:0]          minimo_q, minimo_d;
   logic [CUENTA_W-1:0] repeticiones_max_q, repeticiones_max_d;
   logic [CUENTA_W-1:0] cuenta_q, cuenta_d;

   logic listo_s;
   logic acepta_s;
   logic a_igual_s, a_mayor_s, a_menor_s;
   logic b_igual_s, b_mayor_s, b_menor_s;

   Comparador8bits u_cmp_max (
      .a     (bus.dato),
      .b     (maximo_q),
      .igual (a_igual_s),
      .mayor (a_mayor_s),
      .menor (a_menor_s)
   );

   Comparador8bits u_cmp_min (
      .a     (bus.dato),
      .b     (minimo_q),
      .igual (b_igual_s),
      .mayor (b_mayor_s),
      .menor (b_menor_s)
   );

   assign listo_s  = (estado_q != ENTREGA);
   assign acepta_s = bus.dato_valido & listo_s;

   // Next-state and datapath update; limpiar overrides both sample accept and ack.
   always_comb begin
      estado_d           = estado_q;
      maximo_d           = maximo_q;
      minimo_d           = minimo_q;
      repeticiones_max_d = repeticiones_max_q;
      cuenta_d           = cuenta_q;

      if (bus.limpiar) begin
         estado_d           = ESPERA;
         maximo_d           = MAX_INICIAL;
         minimo_d           = MIN_INICIAL;
         repeticiones_max_d = CUENTA_CERO;
         cuenta_d           = CUENTA_CERO;
      end else begin
         case (estado_q)
            ESPERA: begin
               if (acepta_s) begin
                  maximo_d           = bus.dato;
                  minimo_d           = bus.dato;
                  repeticiones_max_d = CUENTA_UNO;
                  cuenta_d           = CUENTA_UNO;
                  estado_d           = (LONG_VENTANA == 1) ? ENTREGA : ACUMULA;
               end else begin
                  estado_d = ESPERA;
               end
            end

            ACUMULA: begin
               if (acepta_s) begin
                  case ({a_mayor_s, a_igual_s, a_menor_s})
                     CMP_MAYOR: begin
                        maximo_d           = bus.dato;
                        repeticiones_max_d = CUENTA_UNO;
                     end
                     CMP_IGUAL: begin
                        if (repeticiones_max_q != REP_SAT) begin
                           repeticiones_max_d = repeticiones_max_q + CUENTA_UNO;
                        end else begin
                           repeticiones_max_d = REP_SAT;
                        end
                     end
                     default: begin
                        maximo_d = maximo_q;
                     end
                  endcase

                  case ({b_mayor_s, b_igual_s, b_menor_s})
                     CMP_MENOR: minimo_d = bus.dato;
                     default:   minimo_d = minimo_q;
                  endcase

                  cuenta_d = cuenta_q + CUENTA_UNO;
                  if (cuenta_q == ULTIMA) begin
                     estado_d = ENTREGA;
                  end else begin
                     estado_d = ACUMULA;
                  end
               end else begin
                  estado_d = ACUMULA;
               end
            end

            ENTREGA: begin
               // max/min/repeats stay visible until the next window's first sample.
               if (bus.resultado_ack) begin
                  estado_d = ESPERA;
                  cuenta_d = CUENTA_CERO;
               end else begin
                  estado_d = ENTREGA;
               end
            end

            default: begin
               estado_d           = ESPERA;
               maximo_d           = MAX_INICIAL;
               minimo_d           = MIN_INICIAL;
               repeticiones_max_d = CUENTA_CERO;
               cuenta_d           = CUENTA_CERO;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q           <= ESPERA;
         maximo_q           <= MAX_INICIAL;
         minimo_q           <= MIN_INICIAL;
         repeticiones_max_q <= CUENTA_CERO;
         cuenta_q           <= CUENTA_CERO;
      end else begin
         estado_q           <= estado_d;
         maximo_q           <= maximo_d;
         minimo_q           <= minimo_d;
         repeticiones_max_q <= repeticiones_max_d;
         cuenta_q           <= cuenta_d;
      end
   end

   assign bus.listo            = listo_s;
   assign bus.resultado_valido = (estado_q == ENTREGA);
   assign bus.maximo           = maximo_q;
   assign bus.minimo           = minimo_q;
   assign bus.repeticiones_max = repeticiones_max_q;
   assign bus.cuenta           = cuenta_q;

endmodule

// File: tb/tb_rastreador_max_min.sv
// Bench for rastreador_max_min: three window lengths (4, 1, 255) checked against a queue-based model.
module tb_rastreador_max_min;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] dato = 8'd0;
   logic       dv = 1'b0;
   logic       limpiar = 1'b0;
   logic       ack = 1'b0;
   int         sel = 0;

   rastreador_max_min_if #(.CUENTA_W(8)) b4 ();
   rastreador_max_min_if #(.CUENTA_W(8)) b1 ();
   rastreador_max_min_if #(.CUENTA_W(8)) b255 ();

   assign b4.dato   = dato;
   assign b1.dato   = dato;
   assign b255.dato = dato;
   assign b4.dato_valido   = dv && (sel == 0);
   assign b1.dato_valido   = dv && (sel == 1);
   assign b255.dato_valido = dv && (sel == 2);
   assign b4.limpiar   = limpiar && (sel == 0);
   assign b1.limpiar   = limpiar && (sel == 1);
   assign b255.limpiar = limpiar && (sel == 2);
   assign b4.resultado_ack   = ack && (sel == 0);
   assign b1.resultado_ack   = ack && (sel == 1);
   assign b255.resultado_ack = ack && (sel == 2);

   rastreador_max_min #(.LONG_VENTANA(4),   .CUENTA_W(8)) dut4   (.clk(clk), .rst_n(rst_n), .bus(b4));
   rastreador_max_min #(.LONG_VENTANA(1),   .CUENTA_W(8)) dut1   (.clk(clk), .rst_n(rst_n), .bus(b1));
   rastreador_max_min #(.LONG_VENTANA(255), .CUENTA_W(8)) dut255 (.clk(clk), .rst_n(rst_n), .bus(b255));

   logic [7:0] o_max, o_min, o_rep, o_cnt;
   logic       o_val, o_listo;

   always_comb begin
      case (sel)
         0: begin
            o_max = b4.maximo; o_min = b4.minimo; o_rep = b4.repeticiones_max;
            o_cnt = b4.cuenta; o_val = b4.resultado_valido; o_listo = b4.listo;
         end
         1: begin
            o_max = b1.maximo; o_min = b1.minimo; o_rep = b1.repeticiones_max;
            o_cnt = b1.cuenta; o_val = b1.resultado_valido; o_listo = b1.listo;
         end
         default: begin
            o_max = b255.maximo; o_min = b255.minimo; o_rep = b255.repeticiones_max;
            o_cnt = b255.cuenta; o_val = b255.resultado_valido; o_listo = b255.listo;
         end
      endcase
   end

   int passed = 0;
   int total  = 0;

   // Reference model: the samples of the open window, plus what stays shown once it is empty.
   logic [7:0] q[$];
   int ventana = 4;
   int h_max = 0;
   int h_min = 255;
   int h_rep = 0;

   function automatic int m_max();
      int m = 0;
      foreach (q[i]) if (int'(q[i]) > m) m = int'(q[i]);
      return m;
   endfunction

   function automatic int m_min();
      int m = 255;
      foreach (q[i]) if (int'(q[i]) < m) m = int'(q[i]);
      return m;
   endfunction

   function automatic int m_rep();
      int mx = m_max();
      int n = 0;
      foreach (q[i]) if (int'(q[i]) == mx) n++;
      return (n > 255) ? 255 : n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === 32'(exp)) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset(input int l);
      q.delete();
      ventana = l;
      h_max = 0; h_min = 255; h_rep = 0;
   endtask

   task automatic check_model(input string tag);
      int em, en, er;
      if (q.size() > 0) begin
         em = m_max(); en = m_min(); er = m_rep();
      end else begin
         em = h_max; en = h_min; er = h_rep;
      end
      chk({tag, "_max"},   32'(o_max),   em);
      chk({tag, "_min"},   32'(o_min),   en);
      chk({tag, "_rep"},   32'(o_rep),   er);
      chk({tag, "_cnt"},   32'(o_cnt),   q.size());
      chk({tag, "_val"},   32'(o_val),   (q.size() == ventana) ? 1 : 0);
      chk({tag, "_listo"}, 32'(o_listo), (q.size() == ventana) ? 0 : 1);
   endtask

   // One clock with the given inputs, then advance the model and compare.
   task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                        input logic clr, input logic a);
      dv = v; dato = d; limpiar = clr; ack = a;
      @(posedge clk);
      #1;
      if (clr) begin
         q.delete();
         h_max = 0; h_min = 255; h_rep = 0;
      end else if (q.size() == ventana) begin
         if (a) begin
            h_max = m_max(); h_min = m_min(); h_rep = m_rep();
            q.delete();
         end
      end else if (v) begin
         q.push_back(d);
      end
      check_model(tag);
   endtask

   initial begin
      logic [7:0] w1[4];
      logic [7:0] w2[4];
      w1[0] = 8'd22;  w1[1] = 8'd40; w1[2] = 8'd5; w1[3] = 8'd40;
      w2[0] = 8'd250; w2[1] = 8'd4;  w2[2] = 8'd4; w2[3] = 8'd35;

      // Reset held with a sample offered: nothing may be captured.
      sel = 0; dv = 1'b1; dato = 8'd77;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_max", 32'(o_max), 0);
      chk("rst_min", 32'(o_min), 255);
      chk("rst_rep", 32'(o_rep), 0);
      chk("rst_cnt", 32'(o_cnt), 0);
      chk("rst_val", 32'(o_val), 0);
      dv = 1'b0;
      rst_n = 1'b1;
      model_reset(4);
      cycle("idle", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("idle_listo", 32'(o_listo), 1);

      for (int i = 0; i < 4; i++) cycle("w1", 1'b1, w1[i], 1'b0, 1'b0);
      chk("w1_max", 32'(o_max), 40);
      chk("w1_min", 32'(o_min), 5);
      chk("w1_rep", 32'(o_rep), 2);
      chk("w1_cnt", 32'(o_cnt), 4);
      chk("w1_val", 32'(o_val), 1);
      chk("w1_listo", 32'(o_listo), 0);

      for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 8'd99, 1'b0, 1'b0);
      cycle("ack1", 1'b0, 8'd0, 1'b0, 1'b1);
      chk("ack1_cnt", 32'(o_cnt), 0);
      chk("ack1_val", 32'(o_val), 0);
      chk("ack1_keep_max", 32'(o_max), 40);

      for (int i = 0; i < 4; i++) cycle("w2", 1'b1, w2[i], 1'b0, 1'b0);
      chk("w2_max", 32'(o_max), 250);
      chk("w2_min", 32'(o_min), 4);
      chk("w2_rep", 32'(o_rep), 1);
      cycle("ack2", 1'b0, 8'd0, 1'b0, 1'b1);

      cycle("w3", 1'b1, 8'd22, 1'b0, 1'b0);
      cycle("w3", 1'b1, 8'd22, 1'b0, 1'b0);
      cycle("clr", 1'b1, 8'd70, 1'b1, 1'b0);
      chk("clr_cnt", 32'(o_cnt), 0);
      chk("clr_max", 32'(o_max), 0);
      chk("clr_min", 32'(o_min), 255);
      cycle("clr_after", 1'b0, 8'd0, 1'b0, 1'b0);
      chk("clr_drop_cnt", 32'(o_cnt), 0);

      // Randomized traffic: gaps, ties, stray acks and occasional aborts.
      for (int i = 0; i < 400; i++) begin
         logic       rv, rc, ra;
         logic [7:0] rd;
         rv = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
         rc = ($urandom_range(0, 39) == 0);
         ra = ($urandom_range(0, 2) == 0);
         cycle("rnd", rv, rd, rc, ra);
      end

      sel = 1;
      model_reset(1);
      cycle("l1_a", 1'b1, 8'd0, 1'b0, 1'b0);
      chk("l1_a_val", 32'(o_val), 1);
      chk("l1_a_rep", 32'(o_rep), 1);
      cycle("l1_ack", 1'b0, 8'd0, 1'b0, 1'b1);
      cycle("l1_b", 1'b1, 8'd255, 1'b0, 1'b0);
      chk("l1_b_max", 32'(o_max), 255);
      chk("l1_b_min", 32'(o_min), 255);
      chk("l1_b_cnt", 32'(o_cnt), 1);
      cycle("l1_ack2", 1'b0, 8'd0, 1'b0, 1'b1);

      sel = 2;
      model_reset(255);
      for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 8'd9, 1'b0, 1'b0);
      chk("sat_rep", 32'(o_rep), 255);
      chk("sat_cnt", 32'(o_cnt), 255);
      chk("sat_val", 32'(o_val), 1);
      chk("sat_max", 32'(o_max), 9);
      cycle("sat_ack", 1'b0, 8'd0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
